// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, synchronous imem requests, DEPTH-entry instruction FIFO, redirect flush.
// Optional halt-on-opcode-6'b111111 support is compiled in with `define IF_HALT_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic          halt_q;

  logic          pop;
  logic          push;
  logic          req;
  logic [AW+1:0] occ;

  // Handshake: an instruction transfers on a cycle where inst_valid & inst_ready are both high;
  // inst/inst_pc hold steady while inst_valid & !inst_ready; inst_ready is ignored when !inst_valid.
  always_comb begin
    pop  = (count != '0) & inst_ready;
    occ  = {1'b0, count} + {{(AW+1){1'b0}}, inflight} - {{(AW+1){1'b0}}, pop};
    req  = !redirect & !halt_q & (occ < DEPTH_W);
    push = inflight & !redirect & !halt_q;
  end

  // Reset is folded in so no request is advertised while the unit is held in reset.
  assign imem_req   = rst_n & req;
  assign imem_addr  = pc_q;
  assign inst       = fifo_inst[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign inst_valid = (count != '0);
  assign halted     = halt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect) begin
      // A coincident pop is irrelevant: the whole queue and any in-flight word are dropped.
      pc_q     <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        fifo_inst[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]   <= inflight_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (req) begin
        pc_q        <= pc_q + 32'd4;
        inflight    <= 1'b1;
        inflight_pc <= pc_q;
      end else begin
        inflight    <= 1'b0;
      end
    end
  end

`ifdef IF_HALT_EN
  logic is_halt;
  assign is_halt = (imem_rdata[31:26] == 6'b111111);

  // Flag rises on the edge that pushes the halt word; later responses are then discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else if (redirect) begin
      halt_q <= 1'b0;
    end else if (push && is_halt) begin
      halt_q <= 1'b1;
    end
  end
`else
  assign halt_q = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, backpressure, redirect, halt, mid-stream reset.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  bit          halt_word_en = 1'b0;

  inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_word_en && a == 32'h8) return 32'hFC00_0000;
    return {2'b00, a[31:2]};
  endfunction

  // Synchronous memory: data for a request appears in the following cycle.
  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (dut.count > DEPTH) begin
        miscompares++;
        $display("FAIL fifo_overflow count=%0d max=%0d", dut.count, DEPTH);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic rdy);
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = rdy;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
    tick(); tick(); #1;
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst !== 32'h0 || inst_pc !== 32'h0 ||
        inst_valid !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values req=%b addr=%h inst=%h pc=%h valid=%b halted=%b exp 0/%h/0/0/0/0",
               imem_req, imem_addr, inst, inst_pc, inst_valid, halted, RESET_PC);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL first_request req=%b addr=%h exp 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    apply_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (c < 2) begin
        if (inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL stream_latency c=%0d valid=%b exp 0", c, inst_valid);
        end
      end else if (inst_valid !== 1'b1 || inst !== 32'(c - 2) || inst_pc !== 32'(4 * (c - 2))) begin
        miscompares++;
        $display("FAIL stream c=%0d valid=%b inst=%h pc=%h exp 1/%h/%h",
                 c, inst_valid, inst, inst_pc, 32'(c - 2), 32'(4 * (c - 2)));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] addrs[$];
    apply_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      if (imem_req) addrs.push_back(imem_addr);
      if (c >= 2) begin
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h0) begin
          miscompares++;
          $display("FAIL stall_hold c=%0d valid=%b inst=%h pc=%h exp 1/0/0", c, inst_valid, inst, inst_pc);
        end
      end
      tick();
    end
    vectors++;
    if (addrs.size() != 2 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4) begin
      miscompares++;
      $display("FAIL stall_requests n=%0d exp 2 (addrs 0,4)", addrs.size());
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 32'(k) || inst_pc !== 32'(4 * k)) begin
        miscompares++;
        $display("FAIL resume k=%0d valid=%b inst=%h pc=%h exp 1/%h/%h",
                 k, inst_valid, inst, inst_pc, 32'(k), 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    tick(); tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL redirect_setup valid=%b pc=%h exp 1/0", inst_valid, inst_pc);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_noreq req=%b exp 0", imem_req);
    end
    tick();
    redirect = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_fetch req=%b addr=%h valid=%b exp 1/100/0", imem_req, imem_addr, inst_valid);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_flush valid=%b exp 0", inst_valid);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'h40) begin
      miscompares++;
      $display("FAIL redirect_target valid=%b pc=%h inst=%h exp 1/100/40", inst_valid, inst_pc, inst);
    end
    inst_ready = 1'b1;
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h104 || inst !== 32'h41) begin
      miscompares++;
      $display("FAIL redirect_next valid=%b pc=%h inst=%h exp 1/104/41", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] e;
    apply_reset(1'b1);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204};
    for (int c = 0; c < 20; c++) begin
      redirect = (c == 4);
      redirect_pc = 32'h0000_0203;
      #1;
      if (inst_valid && inst_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL redir_pop_extra c=%0d pc=%h exp none", c, inst_pc);
        end else begin
          e = exp_q.pop_front();
          if (inst_pc !== e || inst !== mem_word(e)) begin
            miscompares++;
            $display("FAIL redir_pop c=%0d pc=%h inst=%h exp %h/%h", c, inst_pc, inst, e, mem_word(e));
          end
        end
      end
      if (exp_q.size() == 0) break;
      tick();
    end
    redirect = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL redir_pop_timeout left=%0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_halt();
    logic [31:0] addrs[$];
    logic [31:0] e;
    halt_word_en = 1'b1;
    apply_reset(1'b1);
`ifdef IF_HALT_EN
    exp_q = '{32'h0, 32'h4, 32'h8};
`else
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
`endif
    for (int c = 0; c < 10; c++) begin
      if (imem_req) addrs.push_back(imem_addr);
      vectors++;
`ifdef IF_HALT_EN
      if (halted !== (c >= 4)) begin
`else
      if (halted !== 1'b0) begin
`endif
        miscompares++;
        $display("FAIL halted_flag c=%0d halted=%b", c, halted);
      end
      if (inst_valid && inst_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL halt_extra c=%0d pc=%h exp none", c, inst_pc);
        end else begin
          e = exp_q.pop_front();
          if (inst_pc !== e || inst !== mem_word(e)) begin
            miscompares++;
            $display("FAIL halt_stream c=%0d pc=%h inst=%h exp %h/%h", c, inst_pc, inst, e, mem_word(e));
          end
        end
      end
`ifndef IF_HALT_EN
      if (exp_q.size() == 0) break;
`endif
      tick();
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL halt_missing left=%0d exp 0", exp_q.size());
    end
`ifdef IF_HALT_EN
    vectors++;
    if (addrs.size() != 4 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 ||
        addrs[2] !== 32'h8 || addrs[3] !== 32'hC) begin
      miscompares++;
      $display("FAIL halt_requests n=%0d exp 4 (addrs 0,4,8,c)", addrs.size());
    end
    redirect = 1'b1; redirect_pc = 32'h0;
    #1;
    vectors++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_redirect_cycle halted=%b req=%b exp 1/0", halted, imem_req);
    end
    tick();
    redirect = 1'b0;
    #1;
    vectors++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL halt_clear halted=%b req=%b addr=%h exp 0/1/0", halted, imem_req, imem_addr);
    end
    tick(); tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0) begin
      miscompares++;
      $display("FAIL halt_refetch valid=%b pc=%h inst=%h exp 1/0/0", inst_valid, inst_pc, inst);
    end
`endif
    halt_word_en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    apply_reset(1'b0);
    for (int c = 0; c < 10; c++) tick();
    vectors++;
    if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL full_before_reset valid=%b req=%b exp 1/0", inst_valid, imem_req);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset valid=%b req=%b exp 0/0", inst_valid, imem_req);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || inst !== 32'h0 || imem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL held_reset valid=%b req=%b inst=%h addr=%h exp 0/0/0/%h",
               inst_valid, imem_req, inst, imem_addr, RESET_PC);
    end
    rst_n = 1'b1; inst_ready = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_req req=%b addr=%h valid=%b exp 1/%h/0", imem_req, imem_addr, inst_valid, RESET_PC);
    end
    tick(); tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL restart_first valid=%b inst=%h pc=%h exp 1/0/0", inst_valid, inst, inst_pc);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst !== 32'h1 || inst_pc !== 32'h4) begin
      miscompares++;
      $display("FAIL restart_second valid=%b inst=%h pc=%h exp 1/1/4", inst_valid, inst, inst_pc);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_halt();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
